// File: rtl/tile_query_arbiter.sv
// rtl/tile_query_arbiter.sv - round-robin arbiter sharing one tile-map lookup port
// Grants one corner probe per cycle, tracks it through the map latency and returns the result.
module tile_query_arbiter #(
  parameter int N_REQ    = 4,
  parameter int MAP_LAT  = 1,
  parameter int MAX_LOCK = 8,
  parameter int X_LIM    = 640,
  parameter int Y_LIM    = 480
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req,
  input  logic [N_REQ-1:0]     lock,
  input  logic [10*N_REQ-1:0]  req_x,
  input  logic [10*N_REQ-1:0]  req_y,
  output logic [N_REQ-1:0]     gnt,
  output logic [9:0]           map_x,
  output logic [9:0]           map_y,
  input  logic                 map_blockType,
  output logic [N_REQ-1:0]     rsp_valid,
  output logic                 rsp_blockType
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = (MAX_LOCK > 2) ? $clog2(MAX_LOCK) : 1;

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] owner_q;
  logic             owner_vld_q;
  logic [CNT_W-1:0] lock_cnt_q;
  logic [9:0]       map_x_q, map_y_q;
  logic [N_REQ-1:0] rsp_valid_q;
  logic             rsp_bt_q;

  logic [MAP_LAT:0] tag_vld_q;
  logic [MAP_LAT:0] tag_oob_q;
  logic [IDX_W-1:0] tag_idx_q [MAP_LAT+1];

  logic [IDX_W-1:0] rr_idx, cand, gnt_idx;
  logic             rr_found, lock_hold, gnt_any, gnt_oob;
  logic [9:0]       gnt_x, gnt_y;

  // Round-robin scan starting just after the last granted requester.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    cand     = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = IDX_W'((int'(ptr_q) + k) % N_REQ);
      if (!rr_found && req[cand]) begin
        rr_found = 1'b1;
        rr_idx   = cand;
      end
    end
  end

  // A lock is honoured only until the counter reaches MAX_LOCK-1, then the scan decides once.
  always_comb begin
    lock_hold = owner_vld_q && req[owner_q] && lock[owner_q] &&
                (int'(lock_cnt_q) < MAX_LOCK - 1);
    gnt_idx   = lock_hold ? owner_q : rr_idx;
    gnt_any   = !rst && (lock_hold || rr_found);
    gnt       = gnt_any ? (N_REQ'(1) << gnt_idx) : '0;
    gnt_x     = req_x[10*int'(gnt_idx) +: 10];
    gnt_y     = req_y[10*int'(gnt_idx) +: 10];
    gnt_oob   = (int'(gnt_x) >= X_LIM) || (int'(gnt_y) >= Y_LIM);
    ptr_d     = gnt_any ? gnt_idx : ptr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= IDX_W'(N_REQ - 1);
      owner_q     <= '0;
      owner_vld_q <= 1'b0;
      lock_cnt_q  <= '0;
      map_x_q     <= '0;
      map_y_q     <= '0;
      rsp_valid_q <= '0;
      rsp_bt_q    <= 1'b0;
      tag_vld_q   <= '0;
      tag_oob_q   <= '0;
      for (int i = 0; i <= MAP_LAT; i++) tag_idx_q[i] <= '0;
    end else begin
      ptr_q <= ptr_d;
      if (gnt_any) begin
        map_x_q     <= gnt_x;
        map_y_q     <= gnt_y;
        lock_cnt_q  <= lock_hold ? lock_cnt_q + CNT_W'(1) : '0;
        owner_vld_q <= lock[gnt_idx];
        owner_q     <= gnt_idx;
      end
      tag_vld_q    <= {tag_vld_q[MAP_LAT-1:0], gnt_any};
      tag_oob_q    <= {tag_oob_q[MAP_LAT-1:0], gnt_oob};
      tag_idx_q[0] <= gnt_idx;
      for (int i = 1; i <= MAP_LAT; i++) tag_idx_q[i] <= tag_idx_q[i-1];
      // The tag at the last stage lines up with the map data for its coordinates.
      if (tag_vld_q[MAP_LAT]) begin
        rsp_valid_q <= N_REQ'(1) << tag_idx_q[MAP_LAT];
        rsp_bt_q    <= tag_oob_q[MAP_LAT] | map_blockType;
      end else begin
        rsp_valid_q <= '0;
      end
    end
  end

  assign map_x         = map_x_q;
  assign map_y         = map_y_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_blockType = rsp_bt_q;

endmodule

// File: tb/tb_tile_query_arbiter.sv
// tb/tb_tile_query_arbiter.sv - scoreboard bench for tile_query_arbiter
module tb_tile_query_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [3:0]  lock = '0;
  logic [39:0] req_x = '0;
  logic [39:0] req_y = '0;
  logic [3:0]  gnt, rsp_valid;
  logic [9:0]  map_x, map_y;
  logic        map_bt = 1'b0;
  logic        rsp_bt;

  always #5 clk = ~clk;

  tile_query_arbiter dut (
    .clk(clk), .rst(rst), .req(req), .lock(lock), .req_x(req_x), .req_y(req_y),
    .gnt(gnt), .map_x(map_x), .map_y(map_y), .map_blockType(map_bt),
    .rsp_valid(rsp_valid), .rsp_blockType(rsp_bt)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Tile map with one cycle of read latency: solid where the low nibble of x is 4.
  always @(posedge clk) map_bt <= (map_x[3:0] == 4'd4);

  typedef struct {
    logic [3:0] v;
    logic       bt;
    int         due;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].due == cyc) begin
      mon_e = sb.pop_front();
      chk("rsp_valid", 32'(rsp_valid), 32'(mon_e.v));
      chk("rsp_blockType", 32'(rsp_bt), 32'(mon_e.bt));
    end else if (rsp_valid !== 4'b0000) begin
      checks++;
      errors++;
      $display("FAIL rsp_spurious: got %0h expected 0 (cycle %0d)", rsp_valid, cyc);
    end
  end

  task automatic step(input logic [3:0] eg, input logic ebt, input bit push, input string name);
    @(negedge clk);
    chk(name, 32'(gnt), 32'(eg));
    if (push && eg != 4'b0000) sb.push_back('{v: eg, bt: ebt, due: cyc + 3});
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; lock = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic set_xy(input int i, input logic [9:0] x, input logic [9:0] y);
    req_x[10*i +: 10] = x;
    req_y[10*i +: 10] = y;
  endtask

  logic       bt_idx [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  int         lock_seq [13] = '{0, 1, 2, 2, 2, 2, 2, 2, 2, 2, 3, 0, 1};
  logic [9:0] oob_x  [4] = '{10'd1020, 10'd639, 10'd3, 10'd640};
  logic [9:0] oob_y  [4] = '{10'd5, 10'd479, 10'd480, 10'd0};
  logic       oob_bt [4] = '{1'b1, 1'b0, 1'b1, 1'b1};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset state, with requests pending during reset.
    req = 4'b1111;
    @(negedge clk);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_map_x", 32'(map_x), 0);
    chk("rst_map_y", 32'(map_y), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_bt", 32'(rsp_bt), 0);
    @(posedge clk);
    #1;
    rst = 1'b0; req = '0;

    // Single query, latency and registered map coordinates.
    req = 4'b0001; set_xy(0, 10'd100, 10'd200);
    step(4'b0001, 1'b1, 1, "t1_gnt");
    req = '0;
    @(negedge clk);
    chk("t1_map_x", 32'(map_x), 100);
    chk("t1_map_y", 32'(map_y), 200);
    idle(5);

    // Plain round robin over all four requesters.
    do_reset();
    set_xy(0, 10'd100, 10'd10); set_xy(1, 10'd53, 10'd10);
    set_xy(2, 10'd20, 10'd10);  set_xy(3, 10'd7, 10'd10);
    req = 4'b1111;
    for (int k = 0; k < 8; k++) step(4'b0001 << (k % 4), bt_idx[k % 4], 1, "t2_rr_gnt");
    req = '0;
    idle(5);

    // Requester 2 holds its lock until the counter forces a yield.
    do_reset();
    req = 4'b1111; lock = 4'b0100;
    for (int k = 0; k < 13; k++) step(4'b0001 << lock_seq[k], bt_idx[lock_seq[k]], 1, "t3_lock_gnt");
    req = '0; lock = '0;
    idle(5);

    // Bounds forcing, back to back from one requester.
    do_reset();
    req = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      set_xy(0, oob_x[k], oob_y[k]);
      step(4'b0001, oob_bt[k], 1, "t4_oob_gnt");
    end
    req = '0;
    idle(5);

    // Reset while a query is in flight: its response must never appear.
    do_reset();
    set_xy(0, 10'd52, 10'd10); set_xy(1, 10'd100, 10'd200);
    req = 4'b0010;
    step(4'b0010, 1'b0, 0, "t5_gnt_pre");
    rst = 1'b1; req = 4'b0011;
    step(4'b0000, 1'b0, 0, "t5_gnt_in_rst");
    chk("t5_map_x", 32'(map_x), 0);
    chk("t5_map_y", 32'(map_y), 0);
    rst = 1'b0;
    step(4'b0001, 1'b1, 1, "t5_gnt_post0");
    step(4'b0010, 1'b1, 1, "t5_gnt_post1");
    req = '0;
    idle(5);

    // Requester 1 gives up while requester 0 keeps the grant by lock.
    do_reset();
    set_xy(0, 10'd7, 10'd10); set_xy(1, 10'd100, 10'd10);
    req = 4'b0011; lock = 4'b0001;
    step(4'b0001, 1'b0, 1, "t6_gnt");
    step(4'b0001, 1'b0, 1, "t6_gnt");
    req = 4'b0001;
    step(4'b0001, 1'b0, 1, "t6_gnt");
    req = '0; lock = '0;
    step(4'b0000, 1'b0, 0, "t6_idle");
    step(4'b0000, 1'b0, 0, "t6_idle");
    idle(5);

    chk("sb_empty", 32'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
